// File: rtl/hbmc_rx_capture.sv
// Turns RWDS edges into DQ captures, pairs them into 2*DQ_WIDTH words and queues them in a FWFT FIFO.
// A word completed in cycle N is on rd_data in N+1; when the FIFO is full and not popping, the new word is dropped and flagged.
module hbmc_rx_capture #(
  parameter int DQ_WIDTH        = 8,
  parameter int SERDES_RATIO    = 6,
  parameter int FIFO_DEPTH      = 16,
  parameter int RST_HOLD_CYCLES = 2
) (
  input  logic                               iserdes_clkdiv,
  input  logic                               arst_n,
  input  logic                               capture_en,
  input  logic [SERDES_RATIO-1:0]            rwds_q,
  input  logic [DQ_WIDTH*SERDES_RATIO-1:0]   dq_q,
  input  logic                               err_clr,
  output logic [2*DQ_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               ovf_err,
  output logic                               edge_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = 2 * DQ_WIDTH;
  localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD_CYCLES);

  logic                    r_rwds_prev;
  logic [3:0]              r_hold_cnt;
  logic                    r_phase;
  logic [DQ_WIDTH-1:0]     r_upper;
  logic [WW-1:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_ovf_err;
  logic                    r_edge_err;

  logic [SERDES_RATIO-1:0] w_edge;
  logic [1:0]              w_n_edges;
  logic                    w_extra;
  logic [DQ_WIDTH-1:0]     w_slice0;
  logic [DQ_WIDTH-1:0]     w_slice1;
  logic                    w_active;
  logic                    w_phase_nxt;
  logic [DQ_WIDTH-1:0]     w_upper_nxt;
  logic                    w_push;
  logic [WW-1:0]           w_word;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_wr;
  logic                    w_ovf_set;
  logic                    w_edge_set;

  // Oldest sample (MSB) compares against the last sample of the previous cycle.
  assign w_edge   = rwds_q ^ {r_rwds_prev, rwds_q[SERDES_RATIO-1:1]};
  assign w_active = capture_en && (r_hold_cnt == 4'd0);

  always_comb begin
    w_n_edges = 2'd0;
    w_extra   = 1'b0;
    w_slice0  = '0;
    w_slice1  = '0;
    for (int k = SERDES_RATIO - 1; k >= 0; k--) begin
      if (w_edge[k]) begin
        if (w_n_edges == 2'd0)      w_slice0 = dq_q[k*DQ_WIDTH +: DQ_WIDTH];
        else if (w_n_edges == 2'd1) w_slice1 = dq_q[k*DQ_WIDTH +: DQ_WIDTH];
        else                        w_extra  = 1'b1;
        if (w_n_edges != 2'd2) w_n_edges = w_n_edges + 2'd1;
      end
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_upper_nxt = r_upper;
    w_push      = 1'b0;
    w_word      = '0;
    if (!capture_en) begin
      w_phase_nxt = 1'b0;
    end else if (w_active) begin
      if (w_n_edges == 2'd1) begin
        if (!r_phase) begin
          w_upper_nxt = w_slice0;
          w_phase_nxt = 1'b1;
        end else begin
          w_push      = 1'b1;
          w_word      = {r_upper, w_slice0};
          w_phase_nxt = 1'b0;
        end
      end else if (w_n_edges == 2'd2) begin
        // With a pending upper half, the second capture starts the next word.
        w_push = 1'b1;
        if (!r_phase) begin
          w_word = {w_slice0, w_slice1};
        end else begin
          w_word      = {r_upper, w_slice0};
          w_upper_nxt = w_slice1;
        end
      end
    end
  end

  assign w_pop      = (r_count != '0) && rd_ready;
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_wr       = w_push && (!w_full || w_pop);
  assign w_ovf_set  = w_push && w_full && !w_pop;
  assign w_edge_set = w_active && w_extra;

  always_ff @(posedge iserdes_clkdiv or negedge arst_n) begin
    if (!arst_n) begin
      r_rwds_prev <= 1'b0;
      r_hold_cnt  <= HOLD_INIT;
      r_phase     <= 1'b0;
      r_upper     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf_err   <= 1'b0;
      r_edge_err  <= 1'b0;
    end else begin
      r_rwds_prev <= rwds_q[0];
      if (r_hold_cnt != 4'd0) r_hold_cnt <= r_hold_cnt - 4'd1;
      r_phase <= w_phase_nxt;
      r_upper <= w_upper_nxt;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
      if (w_ovf_set)    r_ovf_err <= 1'b1;
      else if (err_clr) r_ovf_err <= 1'b0;
      if (w_edge_set)   r_edge_err <= 1'b1;
      else if (err_clr) r_edge_err <= 1'b0;
    end
  end

  always_ff @(posedge iserdes_clkdiv) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_word;
  end

  assign rd_data    = r_mem[r_rd_ptr];
  assign rd_valid   = (r_count != '0);
  assign fifo_level = r_count;
  assign ovf_err    = r_ovf_err;
  assign edge_err   = r_edge_err;

endmodule

// File: tb/tb_hbmc_rx_capture.sv
// Bench for hbmc_rx_capture (DQ_WIDTH=8, SERDES_RATIO=6, FIFO_DEPTH=4, hold=2).
module tb_hbmc_rx_capture;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        capture_en;
  logic [5:0]  rwds_q;
  logic [47:0] dq_q;
  logic        err_clr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  fifo_level;
  logic        ovf_err;
  logic        edge_err;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb [$];

  typedef struct {
    logic        en;
    logic [5:0]  rwds;
    logic [47:0] dq;
    logic        clr;
    logic        exp_vld;
    logic [15:0] exp_word;
    logic        exp_eerr;
  } vec_t;

  vec_t vecs [16];

  hbmc_rx_capture #(
    .DQ_WIDTH(8), .SERDES_RATIO(6), .FIFO_DEPTH(4), .RST_HOLD_CYCLES(2)
  ) dut (
    .iserdes_clkdiv(clk), .arst_n(arst_n), .capture_en(capture_en),
    .rwds_q(rwds_q), .dq_q(dq_q), .err_clr(err_clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .fifo_level(fifo_level), .ovf_err(ovf_err), .edge_err(edge_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [5:0] rw, input logic [47:0] dq,
                       input logic rdy, input logic clr);
    capture_en = en;
    rwds_q     = rw;
    dq_q       = dq;
    rd_ready   = rdy;
    err_clr    = clr;
  endtask

  function automatic logic [47:0] dq2(input logic [7:0] s4, input logic [7:0] s2);
    return {8'hE5, s4, 8'hE3, s2, 8'hE1, 8'hE0};
  endfunction

  function automatic logic [47:0] dq1(input logic [7:0] s0);
    return {40'hC5C4C3C2C1, s0};
  endfunction

  function automatic vec_t mk(input logic en, input logic [5:0] rw, input logic [47:0] dq,
                              input logic clr, input logic vld, input logic [15:0] w,
                              input logic ee);
    vec_t v;
    v.en = en; v.rwds = rw; v.dq = dq; v.clr = clr;
    v.exp_vld = vld; v.exp_word = w; v.exp_eerr = ee;
    return v;
  endfunction

  // Scoreboard: every accepted pop must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (arst_n && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h expected no word", rd_data);
      end else begin
        chk("pop_data", 32'(rd_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1, 6'b000111, 48'h01_02_03_A5_04_05, 0, 0, 16'h0000, 0);
    vecs[1]  = mk(1, 6'b111000, 48'h06_07_08_3C_09_0A, 0, 1, 16'hA53C, 0);
    vecs[2]  = mk(1, 6'b011100, 48'h0B_11_0C_0D_22_0E, 0, 1, 16'h1122, 0);
    vecs[3]  = mk(1, 6'b010101, 48'h0F_44_33_12_13_14, 0, 1, 16'h4433, 1);
    vecs[4]  = mk(1, 6'b111111, 48'h15_15_15_15_15_15, 0, 0, 16'h0000, 1);
    vecs[5]  = mk(0, 6'b111111, 48'h16_16_16_16_16_16, 1, 0, 16'h0000, 0);
    vecs[6]  = mk(1, 6'b000000, 48'h55_16_17_18_19_1A, 0, 0, 16'h0000, 0);
    vecs[7]  = mk(0, 6'b111111, 48'h1B_1B_1B_1B_1B_1B, 0, 0, 16'h0000, 0);
    vecs[8]  = mk(1, 6'b100011, 48'h1C_66_1D_1E_77_1F, 0, 1, 16'h6677, 0);
    vecs[9]  = mk(1, 6'b111110, 48'h21_23_24_25_26_81, 0, 0, 16'h0000, 0);
    vecs[10] = mk(1, 6'b011000, 48'h27_92_28_A3_29_2A, 0, 1, 16'h8192, 0);
    vecs[11] = mk(1, 6'b100000, 48'hB4_C5_2B_2C_2D_2E, 0, 1, 16'hA3B4, 0);
    vecs[12] = mk(1, 6'b000001, 48'h2F_30_31_32_34_D6, 0, 1, 16'hC5D6, 0);
    vecs[13] = mk(1, 6'b101010, 48'h35_E7_F8_36_37_38, 1, 1, 16'hE7F8, 1);
    vecs[14] = mk(1, 6'b000000, 48'h39_39_39_39_39_39, 0, 0, 16'h0000, 1);
    vecs[15] = mk(0, 6'b000000, 48'h3A_3A_3A_3A_3A_3A, 1, 0, 16'h0000, 0);

    // Reset state
    arst_n = 1'b0;
    drive(0, 6'b000000, 48'h0, 0, 0);
    #1;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_edge_err", 32'(edge_err), 32'd0);
    tick(); tick();
    arst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Queue three words plus a half word, then reset mid-burst
    for (int c = 0; c < 3; c++) begin
      drive(1, 6'b011000, dq2(8'h10 + 8'(c), 8'h20 + 8'(c)), 0, 0);
      tick();
    end
    chk("burst_level", 32'(fifo_level), 32'd3);
    drive(1, 6'b000001, dq1(8'hEE), 0, 0);
    tick();
    drive(1, 6'b011000, dq2(8'h71, 8'h72), 0, 0);
    arst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    tick();
    arst_n = 1'b1;
    tick();
    chk("hold_clk1_level", 32'(fifo_level), 32'd0);
    tick();
    chk("hold_clk2_level", 32'(fifo_level), 32'd0);
    drive(1, 6'b000001, dq1(8'hA1), 0, 0);
    tick();
    chk("post_hold_half", 32'(fifo_level), 32'd0);
    drive(1, 6'b111110, dq1(8'hB2), 0, 0);
    sb.push_back(16'hA1B2);
    tick();
    chk("post_hold_word", 32'(fifo_level), 32'd1);
    chk("post_hold_valid", 32'(rd_valid), 32'd1);
    drive(0, 6'b000000, 48'h0, 1, 0);
    tick();
    chk("post_hold_drain", 32'(fifo_level), 32'd0);

    // Overflow with FIFO_DEPTH=4
    for (int c = 0; c < 5; c++) begin
      drive(1, 6'b011000, dq2(8'h80 + 8'(c), 8'h90 + 8'(c)), 0, 0);
      if (c < 4) sb.push_back({8'h80 + 8'(c), 8'h90 + 8'(c)});
      tick();
    end
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(ovf_err), 32'd1);
    drive(0, 6'b000000, 48'h0, 0, 1);
    tick();
    chk("ovf_clr", 32'(ovf_err), 32'd0);
    chk("ovf_clr_level", 32'(fifo_level), 32'd4);
    drive(1, 6'b011000, dq2(8'hAA, 8'hBB), 1, 0);
    sb.push_back(16'hAABB);
    tick();
    chk("full_pushpop_level", 32'(fifo_level), 32'd4);
    chk("full_pushpop_ovf", 32'(ovf_err), 32'd0);
    drive(0, 6'b000000, 48'h0, 1, 0);
    for (int n = 0; n < 10 && fifo_level != 0; n++) tick();
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Table: rd_ready=1, so rd_valid after each vector equals that vector's push
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en, vecs[i].rwds, vecs[i].dq, 1, vecs[i].clr);
      if (vecs[i].exp_vld) sb.push_back(vecs[i].exp_word);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_edge_err", i), 32'(edge_err), 32'(vecs[i].exp_eerr));
    end
    drive(0, 6'b000000, 48'h0, 1, 0);
    tick(); tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_ovf", 32'(ovf_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
